noise_voice: RTL and testbench
==============================

Name: noise_voice

Overview:
- Consumer stage for the LFSR random-bit source.
- Takes its parallel random word and turns it into a band-limited sample-and-hold noise voice at a programmable reload rate.
- Applies a gate-driven linear attack/release gain ramp so key on/off does not click.
- Output is a signed audio sample plus a valid strobe; it feeds the voice mixer once per audio sample tick.

Parameters:
RW, 8, width of random input word and of signed output sample (2..16)
ACC_W, 16, phase accumulator / rate width (8..24)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sample_en  input  1  one-cycle audio sample tick; all voice state advances only on cycles where it is high
rnd_in  input  RW  free-running random word from the LFSR source (unsigned, offset-binary)
rate  input  ACC_W  phase increment; hold reload frequency = f_sample * rate / 2^ACC_W
gate  input  1  note on (1) / off (0), sampled only when sample_en=1
level  input  7  target gain 0..127 (velocity)
sout  output  RW  signed two's-complement noise sample
sout_valid  output  1  one-cycle strobe, sout updated
busy  output  1  high whenever FSM != OFF

Behaviour:
- Decided: one clock, clk; reset rst_n asynchronous active-low. All registers clear immediately on rst_n=0, independent of clk. Reset values:
  - sout=0, sout_valid=0, busy=0
  - acc=0, hold=0, gain=0, FSM=OFF
- Reset asserted mid-note: output silent at once. After release, no output until the next gate-high sample tick.
- Stage 1 (edge of a cycle with sample_en=1):
  - {carry, acc} <= acc + rate, ACC_W+1-bit add with wrap.
  - If carry=1: hold <= rnd_in with MSB inverted (offset-binary to signed). 0xFF->+127, 0x00->-128, 0x80->0 for RW=8.
  - rate=0: hold never reloads.
  - Gain FSM advances (below).
- Stage 2 (next edge):
  - sout <= (hold * {0,gain}) >>> 7, signed product RW+8 bits, arithmetic shift, truncate toward -inf.
  - sout_valid <= 1 for exactly that cycle.
  - Latency is 2 clk edges from the sample_en cycle to sout_valid.
  - sample_en on consecutive clocks is legal; each tick produces its own valid.
- Gain FSM, one step per sample tick:
  - OFF: gain=0. gate=1 -> ATTACK.
  - ATTACK: gate=0 -> RELEASE. Else if gain<level, gain+1. Once gain>=level -> SUSTAIN (no overshoot).
  - SUSTAIN: gain tracks level by +/-1 per tick. gate=0 -> RELEASE.
  - RELEASE: gain-1 per tick. Reaching 0 -> OFF. gate=1 -> ATTACK from the current gain (no reset to 0).
  - Transition and gain step happen on the same tick.
  - level=0 with gate=1: ATTACK -> SUSTAIN immediately, gain stays 0, busy stays 1.
- No sample tick means everything holds, and sout_valid=0.
- rnd_in sampled only on reload ticks; no handshake with the source.

Optional Feature:
- Macro NOISE_VOICE_LPF_EN.
- Defined:
  - Adds a signed RW+2-bit register filt, reset 0.
  - On each stage-1 tick: filt <= filt + ((hold_prev - filt) >>> 2), where hold_prev is hold before this tick's update.
  - Stage 2 multiplies sat(filt to RW bits) instead of hold.
  - Latency unchanged; one-pole lowpass softens the noise.
- Undefined: filt absent, stage 2 uses hold directly.

Test Plan:
- Reset check:
  - Stimulus: rst_n=0 mid-note with gain=100, no clk edge.
  - Response: sout=0, busy=0, sout_valid=0 immediately. After release, gate=1 needs a tick to leave OFF.
- Reload rate:
  - Stimulus: RW=8, ACC_W=16, rate=0x8000, gate=1, level=127 settled, rnd_in=0xFF.
  - Response: hold reloads on every 2nd sample tick only.
  - Change rnd_in to 0x00 between ticks. A reload tick yields hold=-128; a non-reload tick leaves hold unchanged.
- Scaling:
  - rnd_in=0xFF, gain=127 -> sout=126.
  - rnd_in=0x00, gain=127 -> sout=-127.
  - rnd_in=0x80 -> sout=0.
  - Each result appears with sout_valid exactly 2 edges after its sample_en.
- Attack/sustain/release:
  - Stimulus: level=3, gate 0->1.
  - Response: gain 1,2,3 on successive ticks, then SUSTAIN.
  - Set level=1: gain 2,1.
  - Set gate=0: gain 0, FSM OFF, busy drops.
- Retrigger:
  - Stimulus: in RELEASE at gain=40, set gate=1.
  - Response: next tick gain=41 in ATTACK, not 1.
- rate=0 and idle clocks:
  - Stimulus: rate=0, sample_en pulses every 7 clocks.
  - Response: hold constant, one sout_valid per pulse, no valid between pulses.

Source files
------------

// File: rtl/noise_voice.sv
// Sample-and-hold noise voice with a linear attack/sustain/release gain envelope.
// Optional one-pole lowpass on the held value is enabled with macro NOISE_VOICE_LPF_EN.
module noise_voice #(
   parameter int unsigned RW    = 8,
   parameter int unsigned ACC_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_en,
   input  logic [RW-1:0]        rnd_in,
   input  logic [ACC_W-1:0]     rate,
   input  logic                 gate,
   input  logic [6:0]           level,
   output logic signed [RW-1:0] sout,
   output logic                 sout_valid,
   output logic                 busy
);
   localparam int unsigned GW = 7;
   localparam int unsigned PW = RW + 8;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_ATTACK  = 2'd1,
      ST_SUSTAIN = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [GW-1:0]        r_gain;
   logic [GW-1:0]        w_gain_nxt;
   logic [GW-1:0]        w_att_gain;
   logic                 w_att_done;
   logic [GW-1:0]        w_rel_gain;
   logic                 w_rel_off;
   logic [GW-1:0]        w_trk_gain;
   logic                 r_busy;

   logic [ACC_W-1:0]     r_acc;
   logic [ACC_W:0]       w_sum;
   logic signed [RW-1:0] r_hold;
   logic signed [RW-1:0] w_rnd_s;
   logic signed [RW-1:0] w_src;
   logic signed [PW-1:0] w_prod;
   logic                 r_s1_vld;
   logic                 r_valid;
   logic signed [RW-1:0] r_sout;

   // Phase accumulator; its carry-out marks a hold reload.
   assign w_sum   = {1'b0, r_acc} + {1'b0, rate};
   // Offset-binary to two's complement: flip the MSB.
   assign w_rnd_s = {~rnd_in[RW-1], rnd_in[RW-2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_hold <= '0;
      end else if (sample_en) begin
         r_acc <= w_sum[ACC_W-1:0];
         if (w_sum[ACC_W]) begin
            r_hold <= w_rnd_s;
         end
      end
   end

   // Candidate gain steps shared by the envelope states.
   assign w_att_gain = (r_gain < level) ? r_gain + GW'(1) : r_gain;
   assign w_att_done = (w_att_gain >= level);
   assign w_rel_gain = (r_gain == '0) ? '0 : r_gain - GW'(1);
   assign w_rel_off  = (w_rel_gain == '0);
   assign w_trk_gain = (r_gain < level) ? r_gain + GW'(1) :
                       (r_gain > level) ? r_gain - GW'(1) : r_gain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_OFF;
         r_gain  <= '0;
         r_busy  <= 1'b0;
      end else if (sample_en) begin
         r_state <= w_state_nxt;
         r_gain  <= w_gain_nxt;
         r_busy  <= (w_state_nxt != ST_OFF);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gain_nxt  = r_gain;
      case (r_state)
         ST_OFF: begin
            w_gain_nxt = '0;
            if (gate) begin
               w_gain_nxt  = w_att_gain;
               w_state_nxt = w_att_done ? ST_SUSTAIN : ST_ATTACK;
            end
         end
         ST_ATTACK, ST_RELEASE: begin
            if (gate) begin
               w_gain_nxt  = w_att_gain;
               w_state_nxt = w_att_done ? ST_SUSTAIN : ST_ATTACK;
            end else begin
               w_gain_nxt  = w_rel_gain;
               w_state_nxt = w_rel_off ? ST_OFF : ST_RELEASE;
            end
         end
         ST_SUSTAIN: begin
            if (gate) begin
               w_gain_nxt = w_trk_gain;
            end else begin
               w_gain_nxt  = w_rel_gain;
               w_state_nxt = w_rel_off ? ST_OFF : ST_RELEASE;
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
            w_gain_nxt  = '0;
         end
      endcase
   end

`ifdef NOISE_VOICE_LPF_EN
   localparam int unsigned FW = RW + 2;
   localparam logic signed [FW-1:0] SAT_HI = FW'((2 ** (RW - 1)) - 1);
   localparam logic signed [FW-1:0] SAT_LO = ~SAT_HI;

   logic signed [FW-1:0] r_filt;
   logic signed [FW:0]   w_diff;

   // One-pole lowpass toward the pre-update hold value.
   assign w_diff = (FW+1)'(r_hold) - (FW+1)'(r_filt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_filt <= '0;
      end else if (sample_en) begin
         r_filt <= r_filt + FW'(w_diff >>> 2);
      end
   end

   always_comb begin
      if (r_filt > SAT_HI) begin
         w_src = {1'b0, {(RW-1){1'b1}}};
      end else if (r_filt < SAT_LO) begin
         w_src = {1'b1, {(RW-1){1'b0}}};
      end else begin
         w_src = RW'(r_filt);
      end
   end
`else
   assign w_src = r_hold;
`endif

   // Stage 2: scale by gain/128, floor via arithmetic shift.
   assign w_prod = PW'(w_src) * PW'($signed({1'b0, r_gain}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_valid  <= 1'b0;
         r_sout   <= '0;
      end else begin
         r_s1_vld <= sample_en;
         r_valid  <= r_s1_vld;
         if (r_s1_vld) begin
            r_sout <= RW'(w_prod >>> 7);
         end
      end
   end

   assign sout       = r_sout;
   assign sout_valid = r_valid;
   assign busy       = r_busy;

endmodule

// File: tb/tb_noise_voice.sv
// Directed plus randomized bench for noise_voice against an arithmetic reference model.
module tb_noise_voice;
   localparam int unsigned RW    = 8;
   localparam int unsigned ACC_W = 16;
   localparam int HALF = 1 << (RW - 1);
   localparam int WRAP = 1 << ACC_W;
   localparam int M_OFF  = 0;
   localparam int M_RISE = 1;
   localparam int M_HOLD = 2;
   localparam int M_FALL = 3;

   logic                 clk;
   logic                 rst_n;
   logic                 sample_en;
   logic [RW-1:0]        rnd_in;
   logic [ACC_W-1:0]     rate;
   logic                 gate;
   logic [6:0]           level;
   logic signed [RW-1:0] sout;
   logic                 sout_valid;
   logic                 busy;

   int n_checks;
   int n_fail;
   int nv;

   // Reference model state (plain integers).
   int m_acc, m_hold, m_filt, m_gain, m_mode, m_sout;
   bit m_pend, m_valid, m_busy;

   noise_voice #(.RW(RW), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .rnd_in     (rnd_in),
      .rate       (rate),
      .gate       (gate),
      .level      (level),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int clamp(input int v);
      if (v > HALF - 1) return HALF - 1;
      if (v < -HALF) return -HALF;
      return v;
   endfunction

   task automatic model_reset();
      m_acc = 0; m_hold = 0; m_filt = 0; m_gain = 0; m_mode = M_OFF; m_sout = 0;
      m_pend = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
   endtask

   // One clock edge of the reference: output from the previous tick, then this tick.
   task automatic model_edge(input bit se);
      int src, hp, sum, lv;
      if (m_pend) begin
`ifdef NOISE_VOICE_LPF_EN
         src = clamp(m_filt);
`else
         src = m_hold;
`endif
         m_sout = (src * m_gain) >>> 7;
      end
      m_valid = m_pend;
      if (se) begin
         hp  = m_hold;
         sum = m_acc + int'(rate);
         if (sum >= WRAP) begin
            m_hold = int'(rnd_in) - HALF;
            sum    = sum - WRAP;
         end
         m_acc  = sum;
         m_filt = m_filt + ((hp - m_filt) >>> 2);
         lv     = int'(level);
         if (!gate) begin
            if (m_gain > 0) m_gain = m_gain - 1;
            m_mode = (m_gain == 0) ? M_OFF : M_FALL;
         end else if (m_mode == M_HOLD) begin
            if (m_gain < lv) m_gain = m_gain + 1;
            else if (m_gain > lv) m_gain = m_gain - 1;
         end else begin
            if (m_gain < lv) m_gain = m_gain + 1;
            m_mode = (m_gain >= lv) ? M_HOLD : M_RISE;
         end
      end
      m_pend = se;
      m_busy = (m_mode != M_OFF);
   endtask

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input bit se);
      sample_en = se;
      @(posedge clk);
      model_edge(se);
      #1;
      chk("valid", sout_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("sout", $signed(sout), m_sout);
   endtask

   task automatic tick_chk(input string tag, input int exp);
      step(1'b1);
      step(1'b0);
      chk(tag, $signed(sout), exp);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0; sample_en = 1'b0; gate = 1'b0; level = '0; rate = '0; rnd_in = '0;
      model_reset();
      #12;
      chk("rst_sout", $signed(sout), 0);
      chk("rst_valid", sout_valid, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reload every 2nd tick at half rate; settle gain at 127.
      rate = ACC_W'(1 << (ACC_W - 1));
      gate = 1'b1; level = 7'd127; rnd_in = '1;
      repeat (130) step(1'b1);
      tick_chk("scale_pos", 126);
      rnd_in = '0;
      step(1'b1);
      rnd_in = '1;
      step(1'b1);
      step(1'b0);
      chk("noreload_hold", $signed(sout), -127);
      step(1'b1);
      step(1'b0);
      chk("reload_2nd", $signed(sout), 126);
      rnd_in = '0;
      step(1'b1);
      step(1'b1);
      step(1'b0);
      chk("scale_neg", $signed(sout), -127);
      rnd_in = RW'(HALF);
      step(1'b1);
      step(1'b0);
      step(1'b1);
      chk("lat_e1_valid", sout_valid, 0);
      step(1'b0);
      chk("lat_e2_valid", sout_valid, 1);
      chk("scale_zero", $signed(sout), 0);
      step(1'b0);
      chk("lat_e3_valid", sout_valid, 0);

      // Release to OFF while loading hold = -128, then freeze hold.
      rnd_in = '0; gate = 1'b0;
      for (int k = 0; k < 300 && m_busy; k++) step(1'b1);
      chk("release_off", busy, 0);
      rate = '0;

      // Attack/sustain/release with small levels; sout = -gain.
      level = 7'd3; gate = 1'b1;
      tick_chk("att_g1", -1);
      tick_chk("att_g2", -2);
      tick_chk("att_g3", -3);
      tick_chk("sus_g3", -3);
      level = 7'd1;
      tick_chk("sus_g2", -2);
      tick_chk("sus_g1", -1);
      gate = 1'b0;
      tick_chk("rel_g0", 0);
      chk("rel_busy", busy, 0);

      // Retrigger from release at gain 40.
      level = 7'd100; gate = 1'b1;
      repeat (50) step(1'b1);
      gate = 1'b0;
      repeat (10) step(1'b1);
      gate = 1'b1;
      tick_chk("retrig_g41", -41);
      chk("retrig_busy", busy, 1);
      repeat (70) step(1'b1);
      chk("pre_rst_sout", $signed(sout), -100);

      // Asynchronous reset mid-note.
      rst_n = 1'b0;
      #1;
      chk("arst_sout", $signed(sout), 0);
      chk("arst_valid", sout_valid, 0);
      chk("arst_busy", busy, 0);
      model_reset();
      @(posedge clk);
      #1;
      chk("arst_hold_busy", busy, 0);
      rst_n = 1'b1;
      step(1'b0);
      chk("rst_still_off", busy, 0);
      step(1'b1);
      chk("rst_reenter", busy, 1);

      // Load one hold value, then rate=0 with sparse ticks.
      rate = '1; rnd_in = RW'(32); level = 7'd64;
      step(1'b1);
      step(1'b1);
      rate = '0;
      step(1'b0);
      nv = 0;
      repeat (10) begin
         rnd_in = RW'($urandom);
         step(1'b1);
         if (sout_valid) nv++;
         repeat (6) begin
            rnd_in = RW'($urandom);
            step(1'b0);
            if (sout_valid) nv++;
         end
      end
      chk("idle_valids", nv, 10);

      // Randomized traffic against the model.
      repeat (1500) begin
         if ($urandom_range(0, 15) == 0) gate = ~gate;
         if ($urandom_range(0, 31) == 0) level = 7'($urandom);
         if ($urandom_range(0, 63) == 0)
            rate = ($urandom_range(0, 3) == 0) ? '0 : ACC_W'($urandom);
         rnd_in = RW'($urandom);
         step($urandom_range(0, 2) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
